handshake_window_monitor: RTL and testbench

Synthesizable, parametrised multi-channel req/ack protocol monitor. It replaces single-property simulation checkers with a hardware block that can be left in silicon or on FPGA. Each channel checks that every `req` is answered by `ack` within a latency window of [MIN_LAT, MAX_LAT] cycles. It flags early, late (timeout) and stray acks, keeps sticky per-channel cause bits and keeps a saturating violation count readable by debug logic.

---
 rtl/handshake_window_monitor.sv | 162 ++++++++++++++++
 tb/tb_handshake_window_monitor.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_window_monitor.sv
// Multi-channel req/ack latency-window monitor with sticky causes and a saturating violation count.
// All outputs are registered (one cycle after the offending edge). HWM_STABLE_CHECK_EN adds the payload-stability check.
module handshake_window_monitor #(
  parameter int NUM_CH  = 4,
  parameter int MIN_LAT = 1,
  parameter int MAX_LAT = 3,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        ack,
  input  logic [NUM_CH*DATA_W-1:0] data,
  output logic [NUM_CH-1:0]        err_pulse,
  output logic [4*NUM_CH-1:0]      err_cause,
  output logic                     err_any,
  output logic [CNT_W-1:0]         viol_cnt
);

  localparam int LAT_W = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);
  localparam int EV_W  = $clog2(4 * NUM_CH + 1);
  localparam int SUM_W = ((CNT_W > EV_W) ? CNT_W : EV_W) + 1;
  localparam logic [LAT_W-1:0] MIN_L = LAT_W'(MIN_LAT);
  localparam logic [LAT_W-1:0] MAX_L = LAT_W'(MAX_LAT);
  localparam logic [SUM_W-1:0] SAT   = SUM_W'({CNT_W{1'b1}});

  typedef enum logic {IDLE, WAIT} state_t;

  logic [NUM_CH-1:0][3:0] cause_new;

`ifndef HWM_STABLE_CHECK_EN
  logic unused_data;
  assign unused_data = ^data;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t           state, state_nxt;
    logic [LAT_W-1:0] lat, lat_nxt;
    logic [2:0]       cause_fsm;
    logic             cause_unst;
    logic             start;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= IDLE;
        lat   <= '0;
      end else begin
        state <= state_nxt;
        lat   <= lat_nxt;
      end
    end

    always_comb begin
      state_nxt = state;
      lat_nxt   = lat;
      cause_fsm = '0;
      start     = 1'b0;
      case (state)
        IDLE: begin
          cause_fsm[2] = ack[c];
          start        = req[c];
        end
        WAIT: begin
          if (ack[c]) begin
            cause_fsm[0] = (lat < MIN_L);
            state_nxt    = IDLE;
            lat_nxt      = '0;
            start        = req[c];
          end else if (lat == MAX_L) begin
            cause_fsm[1] = 1'b1;
            state_nxt    = IDLE;
            lat_nxt      = '0;
            start        = req[c];
          end else begin
            lat_nxt = lat + LAT_W'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          lat_nxt   = '0;
        end
      endcase
      // A closing ack or timeout with req in the same cycle opens the next window immediately.
      if (start) begin
        state_nxt = WAIT;
        lat_nxt   = LAT_W'(1);
      end
    end

`ifdef HWM_STABLE_CHECK_EN
    logic [DATA_W-1:0] cap, cap_nxt;
    logic              unst_seen, unst_seen_nxt;
    logic [DATA_W-1:0] cur;

    assign cur = data[c*DATA_W +: DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cap       <= '0;
        unst_seen <= 1'b0;
      end else begin
        cap       <= cap_nxt;
        unst_seen <= unst_seen_nxt;
      end
    end

    // Checked on every WAIT cycle, including the one that closes the window.
    always_comb begin
      cap_nxt       = cap;
      unst_seen_nxt = unst_seen;
      cause_unst    = 1'b0;
      if (state == WAIT && !unst_seen && cur != cap) begin
        cause_unst    = 1'b1;
        unst_seen_nxt = 1'b1;
      end
      if (start) begin
        cap_nxt       = cur;
        unst_seen_nxt = 1'b0;
      end
    end
`else
    assign cause_unst = 1'b0;
`endif

    assign cause_new[c] = {cause_unst, cause_fsm};
  end

  logic [NUM_CH-1:0]   pulse_nxt;
  logic [4*NUM_CH-1:0] cause_nxt;
  logic [EV_W-1:0]     ev_sum;
  logic [SUM_W-1:0]    cnt_sum;
  logic [CNT_W-1:0]    cnt_nxt;

  always_comb begin
    pulse_nxt = '0;
    ev_sum    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pulse_nxt[i] = |cause_new[i];
      ev_sum       = ev_sum + EV_W'($countones(cause_new[i]));
    end
    cause_nxt = (clr ? '0 : err_cause) | cause_new;
    cnt_sum   = SUM_W'(clr ? '0 : viol_cnt) + SUM_W'(ev_sum);
    cnt_nxt   = (cnt_sum > SAT) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse <= '0;
      err_cause <= '0;
      err_any   <= 1'b0;
      viol_cnt  <= '0;
    end else begin
      err_pulse <= pulse_nxt;
      err_cause <= cause_nxt;
      err_any   <= |cause_nxt;
      viol_cnt  <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_handshake_window_monitor.sv
// Bench for handshake_window_monitor: two configurations driven in lockstep, directed scenarios plus random traffic vs. a timestamp model.
module tb_handshake_window_monitor;

  logic        clk = 1'b0;
  logic        rst_n, clr;
  logic [3:0]  req, ack;
  logic [31:0] data;

  logic [3:0]  pa, pb;
  logic [15:0] ca, cb;
  logic        anya, anyb;
  logic [7:0]  cnta;
  logic [1:0]  cntb;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  handshake_window_monitor dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .req(req), .ack(ack), .data(data),
    .err_pulse(pa), .err_cause(ca), .err_any(anya), .viol_cnt(cnta));

  handshake_window_monitor #(.MIN_LAT(2), .MAX_LAT(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .req(req), .ack(ack), .data(data),
    .err_pulse(pb), .err_cause(cb), .err_any(anyb), .viol_cnt(cntb));

  // Model: each channel remembers the edge index of its open request (-1 if none).
  int          minl[2] = '{1, 2};
  int          maxl[2] = '{3, 4};
  int          cmax[2] = '{255, 3};
  int          pend[2][4];
  logic [7:0]  capd[2][4];
  bit          useen[2][4];
  logic [3:0]  exp_pulse[2];
  logic [15:0] exp_cause[2];
  int          exp_cnt[2];
  int          cyc = 0;

`ifdef HWM_STABLE_CHECK_EN
  localparam int UNST = 1;
`else
  localparam int UNST = 0;
`endif

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 4; c++) begin
        pend[k][c] = -1; capd[k][c] = '0; useen[k][c] = 1'b0;
      end
      exp_pulse[k] = '0; exp_cause[k] = '0; exp_cnt[k] = 0;
    end
  endtask

  task automatic model_step();
    logic [15:0] newc;
    logic [3:0]  nc;
    logic [7:0]  dc;
    int          ev, kk;
    for (int k = 0; k < 2; k++) begin
      newc = '0; ev = 0;
      for (int c = 0; c < 4; c++) begin
        nc = '0;
        dc = data[c*8 +: 8];
        if (pend[k][c] < 0) begin
          if (ack[c]) nc[2] = 1'b1;
          if (req[c]) begin pend[k][c] = cyc; capd[k][c] = dc; useen[k][c] = 1'b0; end
        end else begin
          kk = cyc - pend[k][c];
`ifdef HWM_STABLE_CHECK_EN
          if (!useen[k][c] && dc !== capd[k][c]) begin nc[3] = 1'b1; useen[k][c] = 1'b1; end
`endif
          if (ack[c] || kk == maxl[k]) begin
            if (ack[c] && kk < minl[k]) nc[0] = 1'b1;
            if (!ack[c]) nc[1] = 1'b1;
            if (req[c]) begin pend[k][c] = cyc; capd[k][c] = dc; useen[k][c] = 1'b0; end
            else pend[k][c] = -1;
          end
        end
        newc[4*c +: 4] = nc;
        exp_pulse[k][c] = |nc;
        ev += $countones(nc);
      end
      exp_cause[k] = (clr ? 16'h0 : exp_cause[k]) | newc;
      exp_cnt[k]   = (clr ? 0 : exp_cnt[k]) + ev;
      if (exp_cnt[k] > cmax[k]) exp_cnt[k] = cmax[k];
    end
    cyc++;
  endtask

  // One active edge: inputs are sampled, the model advances, outputs settle for checking.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; clr = 1'b0; req = '0; ack = '0; data = '0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; req = '0; ack = '0; data = '0;
    #1;
    n_cmp++; if ({pa, ca, anya, cnta} !== 29'h0) begin n_bad++; $display("FAIL reset_a: got %h want 0", {pa, ca, anya, cnta}); end
    n_cmp++; if ({pb, cb, anyb, cntb} !== 23'h0) begin n_bad++; $display("FAIL reset_b: got %h want 0", {pb, cb, anyb, cntb}); end
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_pass();
    apply_reset();
    req = 4'b0001; tick();
    req = '0;      tick();
    ack = 4'b0001; tick();
    ack = '0;
    n_cmp++; if ({pa, ca, cnta} !== 28'h0) begin n_bad++; $display("FAIL pass_a: got %h want 0", {pa, ca, cnta}); end
    n_cmp++; if ({pb, cb, cntb} !== 22'h0) begin n_bad++; $display("FAIL pass_b: got %h want 0", {pb, cb, cntb}); end
  endtask

  task automatic test_timeout_stray();
    apply_reset();
    req = 4'b0010; tick();
    req = '0; tick(); tick();
    n_cmp++; if (pa !== 4'b0000) begin n_bad++; $display("FAIL pre_timeout_pulse: got %b want 0000", pa); end
    tick();
    n_cmp++; if (pa !== 4'b0010) begin n_bad++; $display("FAIL timeout_pulse: got %b want 0010", pa); end
    n_cmp++; if (ca !== 16'h0020 || cnta !== 8'd1) begin n_bad++; $display("FAIL timeout_cause_cnt: got %h/%0d want 0020/1", ca, cnta); end
    n_cmp++; if (cntb !== 2'd0) begin n_bad++; $display("FAIL timeout_b_quiet: got %0d want 0", cntb); end
    ack = 4'b0010; tick();
    n_cmp++; if (ca !== 16'h0060 || cnta !== 8'd2 || pa !== 4'b0010) begin n_bad++; $display("FAIL stray: got %h/%0d/%b want 0060/2/0010", ca, cnta, pa); end
    n_cmp++; if (cntb !== 2'd0 || cb !== 16'h0) begin n_bad++; $display("FAIL stray_b_legal: got %h/%0d want 0/0", cb, cntb); end
    ack = '0; tick();
    n_cmp++; if (pa !== 4'b0000 || anya !== 1'b1) begin n_bad++; $display("FAIL pulse_one_cycle: got %b/%b want 0000/1", pa, anya); end
  endtask

  task automatic test_early_clr();
    apply_reset();
    req = 4'b0100; tick();
    req = '0; ack = 4'b0100; tick();
    n_cmp++; if (cb !== 16'h0100 || cntb !== 2'd1 || pb !== 4'b0100) begin n_bad++; $display("FAIL early_b: got %h/%0d/%b want 0100/1/0100", cb, cntb, pb); end
    n_cmp++; if (ca !== 16'h0 || cnta !== 8'd0) begin n_bad++; $display("FAIL early_a_legal: got %h/%0d want 0/0", ca, cnta); end
    ack = '0; clr = 1'b1; tick();
    clr = 1'b0;
    n_cmp++; if (cb !== 16'h0 || cntb !== 2'd0 || anyb !== 1'b0) begin n_bad++; $display("FAIL clr_b: got %h/%0d/%b want 0/0/0", cb, cntb, anyb); end
  endtask

  task automatic test_saturate();
    apply_reset();
    ack = 4'hF; tick();
    n_cmp++; if (pb !== 4'hF || cntb !== 2'd3 || cnta !== 8'd4) begin n_bad++; $display("FAIL sat_1: got %h/%0d/%0d want f/3/4", pb, cntb, cnta); end
    tick();
    n_cmp++; if (pb !== 4'hF || cntb !== 2'd3 || cnta !== 8'd8) begin n_bad++; $display("FAIL sat_2: got %h/%0d/%0d want f/3/8", pb, cntb, cnta); end
    ack = '0; tick();
    n_cmp++; if (pb !== 4'h0 || cntb !== 2'd3) begin n_bad++; $display("FAIL sat_hold: got %h/%0d want 0/3", pb, cntb); end
    ack = 4'b1001; clr = 1'b1; tick();
    ack = '0; clr = 1'b0;
    n_cmp++; if (ca !== 16'h4004 || cnta !== 8'd2 || cntb !== 2'd2 || anya !== 1'b1) begin n_bad++; $display("FAIL clr_collide: got %h/%0d/%0d want 4004/2/2", ca, cnta, cntb); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    req = 4'b1000; tick();
    req = '0; tick();
    req = 4'b1000; ack = 4'b1000; tick();
    req = '0; ack = '0;
    n_cmp++; if ({pa, pb, cnta, cntb} !== 18'h0) begin n_bad++; $display("FAIL b2b: got %h want 0", {pa, pb, cnta, cntb}); end
    rst_n = 1'b0; #1;
    n_cmp++; if ({pa, ca, anya, cnta} !== 29'h0) begin n_bad++; $display("FAIL async_reset: got %h want 0", {pa, ca, anya, cnta}); end
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++; if ({pa, ca, anya, cnta, pb, cb, anyb, cntb} !== 52'h0) begin n_bad++; $display("FAIL no_late_timeout[%0d]: got %h want 0", i, {pa, ca, anya, cnta}); end
    end
  endtask

  task automatic test_stable();
    apply_reset();
    req = 4'b0001; data[7:0] = 8'hA5; tick();
    req = '0; data[7:0] = 8'h5A; tick();
    n_cmp++; if (ca[3] !== 1'(UNST) || cnta !== 8'(UNST) || pa[0] !== 1'(UNST)) begin n_bad++; $display("FAIL unstable: got %b/%0d/%b want %0d/%0d/%0d", ca[3], cnta, pa[0], UNST, UNST, UNST); end
    ack = 4'b0001; tick();
    ack = '0;
    n_cmp++; if (cnta !== 8'(UNST) || pa !== 4'b0 || cntb !== 2'(UNST)) begin n_bad++; $display("FAIL unstable_once: got %0d/%b/%0d want %0d/0/%0d", cnta, pa, cntb, UNST, UNST); end
  endtask

  task automatic test_random();
    logic [28:0] want_a;
    logic [22:0] want_b;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 4; c++) begin
        req[c] = ($urandom_range(0, 99) < 35);
        ack[c] = ($urandom_range(0, 99) < 30);
        if ($urandom_range(0, 9) == 0) data[c*8 +: 8] = 8'($urandom);
      end
      clr   = ($urandom_range(0, 31) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
      want_a = {exp_pulse[0], exp_cause[0], |exp_cause[0], 8'(exp_cnt[0])};
      want_b = {exp_pulse[1], exp_cause[1], |exp_cause[1], 2'(exp_cnt[1])};
      n_cmp++; if ({pa, ca, anya, cnta} !== want_a) begin n_bad++; $display("FAIL rand_a[%0d]: got %h want %h", i, {pa, ca, anya, cnta}, want_a); end
      n_cmp++; if ({pb, cb, anyb, cntb} !== want_b) begin n_bad++; $display("FAIL rand_b[%0d]: got %h want %h", i, {pb, cb, anyb, cntb}, want_b); end
    end
    req = '0; ack = '0; clr = 1'b0; rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_pass();
    test_timeout_stray();
    test_early_clr();
    test_saturate();
    test_back_to_back();
    test_stable();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
